// File: rtl/hazard_stall_unit_pkg.sv
// Shared CPU pipeline definitions: register-file geometry and the stall FSM
// state type, also used by the forwarding unit.
package hazard_stall_unit_pkg;

  localparam int CPU_REG_W    = 5;
  localparam int CPU_ZERO_REG = 31;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } stall_state_e;

endpackage

// File: rtl/hazard_stall_unit_compare.sv
// Load-use detector: the ID instruction reads the register that the load in
// EX is about to write. The hard-wired zero register is never a hazard.
module hazard_compare
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_W    = CPU_REG_W,
  parameter int ZERO_REG = CPU_ZERO_REG
) (
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             lu
);

  localparam logic [REG_W-1:0] ZERO_ADDR = REG_W'(ZERO_REG);

  logic rn_hit;
  logic rm_hit;

  assign rn_hit = id_uses_rn & (id_rn == ex_rd);
  assign rm_hit = id_uses_rm & (id_rm == ex_rd);
  assign lu     = ex_mem_read & (ex_rd != ZERO_ADDR) & (rn_hit | rm_hit);

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard control: per-cycle enable/flush/bubble decisions for the
// five stage registers, plus a saturating stall counter and memory timeout flag.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_W        = CPU_REG_W,
  parameter int ZERO_REG     = CPU_ZERO_REG,
  parameter int CNT_W        = 16,
  parameter int MAX_MEM_WAIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  localparam int                WAIT_W   = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_MEM_WAIT);

  stall_state_e      state_q, state_nx;
  logic [WAIT_W-1:0] wait_q, wait_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              timeout_q, timeout_nx;
  logic              lu;

  function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
    return (v == WAIT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_compare #(
    .REG_W    (REG_W),
    .ZERO_REG (ZERO_REG)
  ) u_compare (
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_uses_rn  (id_uses_rn),
    .id_uses_rm  (id_uses_rm),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .lu          (lu)
  );

  // Outputs are purely combinational so the stage registers see them at the next edge.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!reset) begin
      // reset overrides any freeze in the same cycle
    end else if (mem_busy) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (lu) begin
      // the branch is re-evaluated once the load result can be forwarded
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end else if (br_taken) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_nx   = state_q;
    wait_nx    = wait_q;
    cnt_nx     = cnt_q;
    timeout_nx = timeout_q;
    if (mem_busy) begin
      state_nx = MEM_WAIT;
      wait_nx  = sat_inc_wait(wait_q);
      if (wait_nx == WAIT_MAX) timeout_nx = 1'b1;
    end else if (state_q == MEM_WAIT) begin
      state_nx = RUN;
      wait_nx  = '0;
    end
    if (mem_busy | lu) cnt_nx = sat_inc_cnt(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_nx;
      wait_q    <= wait_nx;
      cnt_q     <= cnt_nx;
      timeout_q <= timeout_nx;
    end
  end

  assign stall_count = cnt_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: vector table plus multi-cycle
// sequences for memory waits, timeout, reset mid-wait and counter saturation.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic       id_uses_rn, id_uses_rm, ex_mem_read, br_taken, mem_busy;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble;
  logic [15:0] stall_count;
  logic       mem_timeout;

  always #5 clk = ~clk;

  hazard_stall_unit #(
    .REG_W        (5),
    .ZERO_REG     (31),
    .CNT_W        (16),
    .MAX_MEM_WAIT (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_uses_rn  (id_uses_rn),
    .id_uses_rm  (id_uses_rm),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .br_taken    (br_taken),
    .mem_busy    (mem_busy),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .stall_count (stall_count),
    .mem_timeout (mem_timeout)
  );

  // en is {pc, ifid, idex, exmem, memwb}; cnt/to are the values after the edge
  typedef struct {
    logic        rst;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic        urn;
    logic        urm;
    logic        emr;
    logic [4:0]  exrd;
    logic        br;
    logic        busy;
    logic [4:0]  en;
    logic        flush;
    logic        bubble;
    logic [15:0] cnt;
    logic        to;
  } vec_t;

  typedef struct {
    logic [4:0]  en;
    logic        flush;
    logic        bubble;
    logic [15:0] cnt;
    logic        to;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset       = v.rst;
    id_rn       = v.rn;
    id_rm       = v.rm;
    id_uses_rn  = v.urn;
    id_uses_rm  = v.urm;
    ex_mem_read = v.emr;
    ex_rd       = v.exrd;
    br_taken    = v.br;
    mem_busy    = v.busy;
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    apply(v);
    sb.push_back('{en: v.en, flush: v.flush, bubble: v.bubble, cnt: v.cnt, to: v.to});
    #2;
    if (sb.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".en"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(e.en));
      chk({tag, ".flush"}, 32'(ifid_flush), 32'(e.flush));
      chk({tag, ".bubble"}, 32'(idex_bubble), 32'(e.bubble));
      @(posedge clk);
      #1;
      chk({tag, ".stall_count"}, 32'(stall_count), 32'(e.cnt));
      chk({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(e.to));
    end
  endtask

  // Canned stimulus: lu uses ex_rd=3 read through rn; rst=1 means released.
  function automatic vec_t mk(input logic rst, input logic busy, input logic lu_on,
                              input logic br, input logic [4:0] en, input logic flush,
                              input logic bubble, input logic [15:0] cnt, input logic to);
    vec_t v;
    v = '{rst: rst, rn: 5'd3, rm: 5'd0, urn: 1'b1, urm: 1'b0, emr: lu_on, exrd: 5'd3,
          br: br, busy: busy, en: en, flush: flush, bubble: bubble, cnt: cnt, to: to};
    return v;
  endfunction

  initial begin
    reset = 1'b0; id_rn = '0; id_rm = '0; ex_rd = '0;
    id_uses_rn = 1'b0; id_uses_rm = 1'b0; ex_mem_read = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;

    //        rst   rn     rm     urn   urm   emr   exrd   br    busy  en        fl    bub   cnt     to
    vecs[0]  = '{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 16'd0, 1'b0};
    vecs[1]  = '{1'b1, 5'd3,  5'd0,  1'b1, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 5'b00111, 1'b0, 1'b1, 16'd1, 1'b0};
    vecs[2]  = '{1'b1, 5'd31, 5'd0,  1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 16'd1, 1'b0};
    vecs[3]  = '{1'b1, 5'd0,  5'd7,  1'b1, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 5'b00111, 1'b0, 1'b1, 16'd2, 1'b0};
    vecs[4]  = '{1'b1, 5'd5,  5'd5,  1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 16'd2, 1'b0};
    vecs[5]  = '{1'b1, 5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 5'd9,  1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 16'd2, 1'b0};
    vecs[6]  = '{1'b1, 5'd4,  5'd0,  1'b1, 1'b0, 1'b1, 5'd4,  1'b1, 1'b0, 5'b00111, 1'b0, 1'b1, 16'd3, 1'b0};
    vecs[7]  = '{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 5'b11111, 1'b1, 1'b0, 16'd3, 1'b0};
    vecs[8]  = '{1'b1, 5'd4,  5'd0,  1'b1, 1'b0, 1'b1, 5'd4,  1'b1, 1'b1, 5'b00000, 1'b0, 1'b0, 16'd4, 1'b0};
    vecs[9]  = '{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 16'd5, 1'b0};
    vecs[10] = '{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 16'd6, 1'b0};
    vecs[11] = '{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 5'b11111, 1'b1, 1'b0, 16'd6, 1'b0};
    vecs[12] = '{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 16'd6, 1'b0};

    // reset while busy and hazarded: no freeze, state cleared
    step(mk(1'b0, 1'b1, 1'b1, 1'b1, 5'b11111, 1'b0, 1'b0, 16'd0, 1'b0), "reset");

    for (int i = 0; i < 13; i++) step(vecs[i], $sformatf("vec%0d", i));

    // 10-cycle wait: timeout sets on the 8th busy edge and stays
    for (int k = 1; k <= 10; k++)
      step(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 16'(6 + k), (k >= 8)),
           $sformatf("wait10_%0d", k));
    step(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 16'd16, 1'b1), "wait10_release");

    // reset mid-wait drops the freeze and clears flag and counter
    step(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 16'd17, 1'b1), "midwait_busy");
    step(mk(1'b0, 1'b1, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 16'd0, 1'b0), "midwait_reset");

    // wait counter restarted by reset: 7 busy cycles must not time out
    for (int k = 1; k <= 7; k++)
      step(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 16'(k), 1'b0),
           $sformatf("wait7_%0d", k));
    step(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 16'd7, 1'b0), "wait7_release");
    // a fresh wait after release also starts from zero
    for (int k = 1; k <= 7; k++)
      step(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 16'(7 + k), 1'b0),
           $sformatf("wait7b_%0d", k));

    // saturation: 65534 load-use stalls, then 3 more
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 16'd0, 1'b0), "sat_reset");
    @(negedge clk);
    apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 5'b00111, 1'b0, 1'b1, 16'd0, 1'b0));
    repeat (65534) @(posedge clk);
    step(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 16'hFFFE, 1'b0), "sat_preload");
    for (int k = 1; k <= 3; k++)
      step(mk(1'b1, 1'b0, 1'b1, 1'b0, 5'b00111, 1'b0, 1'b1, 16'hFFFF, 1'b0),
           $sformatf("sat_%0d", k));
    step(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 16'hFFFF, 1'b0), "sat_busy");

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
